// File: rtl/cache_writeback_buffer_pkg.sv
// Shared definitions for the data-cache write-back path: AXI encodings and
// the write-back FSM state type. Also imported by the miss controller and
// the refill path, so keep it free of block-specific parameters.
package cache_writeback_buffer_pkg;

  // AXI burst type, transfer size and response encodings used by the cache.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

  // Write-back buffer states; IDLE means the entry is free.
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_e;

  // Anything other than OKAY (SLVERR, DECERR, EXOKAY on a normal write) is
  // reported as a bus error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/cache_writeback_buffer.sv
// Single-entry dirty-victim write-back buffer. Captures one evicted line
// and sends it to memory as a single AXI INCR write burst of 32-bit beats.
// A combinational address query lets the miss controller hold off a refill
// of a line whose newest data is still sitting in this buffer.
module cache_writeback_buffer
  import cache_writeback_buffer_pkg::*;
#(
  parameter int         BYTES_PER_LINE = 16,
  parameter int         NUM_LINE       = 256,
  parameter int         OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
  parameter int         INDEX_WIDTH    = $clog2(NUM_LINE),
  parameter int         TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int         WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter logic [3:0] AXI_ID         = 4'd1
) (
  input  logic                        clk,
  input  logic                        resetn,

  // Victim line from the miss controller
  input  logic                        wb_req,
  output logic                        wb_ready,
  input  logic [TAG_WIDTH-1:0]        wb_tag,
  input  logic [INDEX_WIDTH-1:0]      wb_index,
  input  logic [BYTES_PER_LINE*8-1:0] wb_line,
  output logic                        busy,

  // Address-match query
  input  logic [TAG_WIDTH-1:0]        query_tag,
  input  logic [INDEX_WIDTH-1:0]      query_index,
  output logic                        query_hit,

  // AXI write address channel
  output logic [3:0]                  awid,
  output logic [31:0]                 awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,

  // AXI write data channel
  output logic [31:0]                 wdata,
  output logic [3:0]                  wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,

  // AXI write response channel
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,

  output logic                        bus_err
);

  localparam int LINE_WIDTH = BYTES_PER_LINE * 8;
  localparam int BEAT_WIDTH = $clog2(WORDS_PER_LINE);

  // Beat index whose handshake makes the following beat the last one.
  localparam logic [BEAT_WIDTH-1:0] PENULT_BEAT = BEAT_WIDTH'(WORDS_PER_LINE - 2);
  localparam logic [7:0]            BURST_LEN   = 8'(WORDS_PER_LINE - 1);

  wb_state_e                 state_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [INDEX_WIDTH-1:0]    index_q;
  logic [LINE_WIDTH-1:0]     line_q;
  logic [BEAT_WIDTH-1:0]     beat_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      wlast_q;
  logic                      bready_q;
  logic                      bus_err_q;

  logic                      accept;

  // A victim is taken only from IDLE; a request arriving while busy (even in
  // the cycle the B response completes) waits for the next IDLE cycle.
  assign accept = (state_q == WB_IDLE) && wb_req;

  // Latch the victim entry on accept; it stays frozen until the next accept.
  // NOTE: the line register is reset even though it is wide, because the
  // latched contents (and hence awaddr/wdata) are defined as zero after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q   <= '0;
      index_q <= '0;
      line_q  <= '0;
    end else if (accept) begin
      // NOTE: state is always updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      tag_q   <= wb_tag;
      index_q <= wb_index;
      line_q  <= wb_line;
    end
  end

  // Burst sequencer: walks ADDR -> DATA -> RESP and registers every handshake
  // qualifier so valid/ready/last never depend combinationally on the bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WB_IDLE;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      // bus_err is a single-cycle pulse unless re-armed below.
      bus_err_q <= 1'b0;
      unique case (state_q)
        WB_IDLE: begin
          if (wb_req) begin
            state_q   <= WB_ADDR;
            beat_q    <= '0;
            awvalid_q <= 1'b1;
          end
        end
        WB_ADDR: begin
          if (awready) begin
            state_q   <= WB_DATA;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            // Lines are at least two words, so the first beat is never last.
            wlast_q   <= 1'b0;
          end
        end
        WB_DATA: begin
          if (wready) begin
            if (wlast_q) begin
              state_q  <= WB_RESP;
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              // Counter stops on the last beat, so it never wraps mid-burst.
              beat_q  <= beat_q + 1'b1;
              wlast_q <= (beat_q == PENULT_BEAT);
            end
          end
        end
        WB_RESP: begin
          if (bvalid) begin
            state_q   <= WB_IDLE;
            bready_q  <= 1'b0;
            bus_err_q <= resp_is_error(bresp);
          end
        end
        default: begin
          state_q <= WB_IDLE;
        end
      endcase
    end
  end

  // Stall check against the held entry; only meaningful while it is occupied.
  always_comb begin
    // NOTE: a default assignment ahead of any condition keeps this purely
    // combinational; leaving a path unassigned would infer a latch.
    query_hit = 1'b0;
    if (state_q != WB_IDLE) begin
      query_hit = (tag_q == query_tag) && (index_q == query_index);
    end
  end

  // Channel outputs: constants, latched entry fields, or registered flags.
  assign wb_ready = (state_q == WB_IDLE);
  assign busy     = (state_q != WB_IDLE);

  assign awid     = AXI_ID;
  assign awaddr   = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign awlen    = BURST_LEN;
  assign awsize   = AXI_SIZE_4B;
  assign awburst  = AXI_BURST_INCR;
  assign awvalid  = awvalid_q;

  assign wdata    = line_q[{beat_q, 5'd0} +: 32];
  assign wstrb    = AXI_WSTRB_FULL;
  assign wlast    = wlast_q;
  assign wvalid   = wvalid_q;

  assign bready   = bready_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer with the default 16-byte line,
// 256-set geometry (20-bit tag, 8-bit index, 4 beats per burst).
module tb_cache_writeback_buffer;

  logic         clk;
  logic         resetn;
  logic         wb_req;
  logic         wb_ready;
  logic [19:0]  wb_tag;
  logic [7:0]   wb_index;
  logic [127:0] wb_line;
  logic         busy;
  logic [19:0]  query_tag;
  logic [7:0]   query_index;
  logic         query_hit;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         bus_err;

  int errors = 0;
  int checks = 0;

  // Victim lines used by the scenarios (word 0 in the low 32 bits).
  localparam logic [19:0]  T1 = 20'h12345;
  localparam logic [7:0]   I1 = 8'h3A;
  localparam logic [127:0] L1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [31:0]  A1 = 32'h123453A0;

  localparam logic [19:0]  T2 = 20'hABCDE;
  localparam logic [7:0]   I2 = 8'hC5;
  localparam logic [127:0] L2 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [31:0]  A2 = 32'hABCDEC50;

  localparam logic [19:0]  T3 = 20'h00F0F;
  localparam logic [7:0]   I3 = 8'h01;
  localparam logic [127:0] L3 = {32'h0BADF00D, 32'hFEEDFACE, 32'hCAFEBABE, 32'hDEADBEEF};
  localparam logic [31:0]  A3 = 32'h00F0F010;

  cache_writeback_buffer dut (
    .clk         (clk),
    .resetn      (resetn),
    .wb_req      (wb_req),
    .wb_ready    (wb_ready),
    .wb_tag      (wb_tag),
    .wb_index    (wb_index),
    .wb_line     (wb_line),
    .busy        (busy),
    .query_tag   (query_tag),
    .query_index (query_index),
    .query_hit   (query_hit),
    .awid        (awid),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .awburst     (awburst),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; all sampling and driving happens 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a victim in an IDLE cycle and let the next edge take it.
  task automatic accept(input logic [19:0] tag, input logic [7:0] idx,
                        input logic [127:0] line, input bit hold);
    int waited;
    waited = 0;
    while (wb_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: wb_ready=%b expected 1 within 50 cycles", wb_ready);
    end
    wb_tag   = tag;
    wb_index = idx;
    wb_line  = line;
    wb_req   = 1'b1;
    step();
    if (!hold) wb_req = 1'b0;
  endtask

  // Act as the AXI slave from the cycle after accept through the B handshake.
  // Returns the number of edges consumed (6 with a zero-wait slave).
  task automatic serve(input logic [31:0] exp_addr, input logic [127:0] exp_line,
                       input int aw_delay, input bit wtoggle, input logic [1:0] resp,
                       input string name, output int cyc);
    int  hs;
    int  stall;
    int  awhs;
    bit  done;
    hs = 0; stall = 0; awhs = 0; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      awready = (stall >= aw_delay);
      if (awvalid === 1'b1) begin
        checks++;
        if (awaddr !== exp_addr || awlen !== 8'd3 || awsize !== 3'b010 ||
            awburst !== 2'b01 || awid !== 4'd1) begin
          errors++;
          $display("FAIL %s_aw: addr=%h len=%0d size=%b burst=%b id=%0d expected addr=%h len=3 size=010 burst=01 id=1",
                   name, awaddr, awlen, awsize, awburst, awid, exp_addr);
        end
        if (awready) awhs++;
        else stall++;
      end
      wready = wtoggle ? (cyc % 2 == 1) : 1'b1;
      if (wvalid === 1'b1) begin
        checks++;
        if (hs > 3) begin
          errors++;
          $display("FAIL %s_extra_beat: beat %0d offered, expected only 4", name, hs);
        end else if (wdata !== exp_line[hs*32 +: 32] || wlast !== (hs == 3) || wstrb !== 4'hF) begin
          errors++;
          $display("FAIL %s_beat%0d: wdata=%h wlast=%b wstrb=%h expected wdata=%h wlast=%b wstrb=f",
                   name, hs, wdata, wlast, wstrb, exp_line[hs*32 +: 32], (hs == 3));
        end
        if (wready) hs++;
      end
      bvalid = bready;
      bresp  = resp;
      if (bready === 1'b1) done = 1'b1;
      step();
      cyc++;
    end
    bvalid  = 1'b0;
    bresp   = 2'b00;
    awready = 1'b0;
    wready  = 1'b0;
    checks++;
    if (!done || hs != 4 || awhs != 1 || stall != aw_delay) begin
      errors++;
      $display("FAIL %s_burst: done=%0d beats=%0d aw_handshakes=%0d aw_stalls=%0d expected 1/4/1/%0d",
               name, done, hs, awhs, stall, aw_delay);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    step();
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0 || query_hit !== 1'b0 || awvalid !== 1'b0 ||
        wvalid !== 1'b0 || bready !== 1'b0 || wlast !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b hit=%b awv=%b wv=%b bready=%b wlast=%b err=%b expected 1 0 0 0 0 0 0 0",
               wb_ready, busy, query_hit, awvalid, wvalid, bready, wlast, bus_err);
    end
    checks++;
    if (awaddr !== 32'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_latched: awaddr=%h wdata=%h expected 0 0", awaddr, wdata);
    end
  endtask

  task automatic test_single();
    int cyc;
    accept(T1, I1, L1, 1'b0);
    checks++;
    if (awvalid !== 1'b1 || wb_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t1: awvalid=%b wb_ready=%b busy=%b expected 1 0 1", awvalid, wb_ready, busy);
    end
    serve(A1, L1, 0, 1'b0, 2'b00, "single", cyc);
    checks++;
    if (cyc != 6 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_t7: edges=%0d wb_ready=%b expected 6 1", cyc, wb_ready);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL single_bus_err: bus_err=%b expected 0", bus_err);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    accept(T2, I2, L2, 1'b0);
    serve(A2, L2, 5, 1'b1, 2'b00, "backpressure", cyc);
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_idle: wb_ready=%b busy=%b expected 1 0", wb_ready, busy);
    end
  endtask

  task automatic test_query();
    int cyc;
    query_tag   = T1;
    query_index = I1;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++;
      $display("FAIL query_idle: query_hit=%b expected 0", query_hit);
    end
    accept(T1, I1, L1, 1'b0);
    checks++;
    if (query_hit !== 1'b1) begin
      errors++;
      $display("FAIL query_match: query_hit=%b expected 1", query_hit);
    end
    query_index = I1 ^ 8'h01;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++;
      $display("FAIL query_index_bit: query_hit=%b expected 0", query_hit);
    end
    query_index = I1;
    query_tag   = T1 ^ 20'h80000;
    #1;
    checks++;
    if (query_hit !== 1'b0) begin
      errors++;
      $display("FAIL query_tag_bit: query_hit=%b expected 0", query_hit);
    end
    query_tag = T1;
    serve(A1, L1, 0, 1'b0, 2'b00, "query", cyc);
    checks++;
    if (query_hit !== 1'b0) begin
      errors++;
      $display("FAIL query_after_b: query_hit=%b expected 0", query_hit);
    end
    query_tag   = '0;
    query_index = '0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    accept(T1, I1, L1, 1'b1);
    // Next victim presented immediately; wb_req never drops.
    wb_tag   = T2;
    wb_index = I2;
    wb_line  = L2;
    serve(A1, L1, 0, 1'b0, 2'b00, "b2b_first", cyc);
    checks++;
    if (wb_ready !== 1'b1 || busy !== 1'b0 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: wb_ready=%b busy=%b awvalid=%b expected 1 0 0", wb_ready, busy, awvalid);
    end
    step();
    wb_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || awvalid !== 1'b1 || awaddr !== A2) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b awvalid=%b awaddr=%h expected 1 1 %h", busy, awvalid, awaddr, A2);
    end
    serve(A2, L2, 0, 1'b0, 2'b00, "b2b_second", cyc);
  endtask

  task automatic test_error();
    int cyc;
    accept(T3, I3, L3, 1'b0);
    serve(A3, L3, 0, 1'b0, 2'b10, "error", cyc);
    checks++;
    if (bus_err !== 1'b1 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL error_pulse: bus_err=%b wb_ready=%b expected 1 1", bus_err, wb_ready);
    end
    step();
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL error_one_cycle: bus_err=%b expected 0", bus_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    accept(T2, I2, L2, 1'b0);
    awready = 1'b1;
    wready  = 1'b1;
    step();  // address handshake
    step();  // beat 0
    step();  // beat 1
    checks++;
    if (wvalid !== 1'b1 || wdata !== 32'hCCCC0002) begin
      errors++;
      $display("FAIL midburst_beat2: wvalid=%b wdata=%h expected 1 cccc0002", wvalid, wdata);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (wvalid !== 1'b0 || wb_ready !== 1'b1 || busy !== 1'b0 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: wvalid=%b wb_ready=%b busy=%b awvalid=%b expected 0 1 0 0",
               wvalid, wb_ready, busy, awvalid);
    end
    awready = 1'b0;
    wready  = 1'b0;
    #1;
    resetn = 1'b1;
    step();
    accept(T3, I3, L3, 1'b0);
    serve(A3, L3, 0, 1'b0, 2'b00, "after_reset", cyc);
    checks++;
    if (cyc != 6 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_len: edges=%0d wb_ready=%b expected 6 1", cyc, wb_ready);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    wb_req      = 1'b0;
    wb_tag      = '0;
    wb_index    = '0;
    wb_line     = '0;
    query_tag   = '0;
    query_index = '0;
    awready     = 1'b0;
    wready      = 1'b0;
    bresp       = 2'b00;
    bvalid      = 1'b0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_query();
    test_back_to_back();
    test_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
